// File: rtl/sys_bridge_n_pkg.sv
// sys_bridge_n_pkg: FSM encoding, default address map and CP0 interrupt width for the bridge
package sys_bridge_n_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
   localparam int HWINT_W = 6;
   localparam int MAX_DEV = 8;
   localparam logic [32*MAX_DEV-1:0] DEF_BASE = {
      32'h00007F70, 32'h00007F60, 32'h00007F50, 32'h00007F40,
      32'h00007F30, 32'h00007F20, 32'h00007F10, 32'h00007F00};
   localparam logic [32*MAX_DEV-1:0] DEF_MASK = {MAX_DEV{32'hFFFFFFF0}};
endpackage

// File: rtl/sys_bridge_n_addr_dec.sv
// bridge_addr_dec: base/mask window match per device; lowest matching index wins
module bridge_addr_dec
   import sys_bridge_n_pkg::*;
#(
   parameter int N_DEV = 6,
   parameter int IW = 3,
   parameter logic [32*N_DEV-1:0] BASE = DEF_BASE[32*N_DEV-1:0],
   parameter logic [32*N_DEV-1:0] MASK = DEF_MASK[32*N_DEV-1:0]
)(
   input  logic [29:0]      PrAddr,
   output logic [N_DEV-1:0] hit,
   output logic [IW-1:0]    idx,
   output logic             any_hit
);
   always_comb begin
      hit = '0;
      idx = '0;
      for (int i = N_DEV - 1; i >= 0; i--) begin
         hit[i] = ({PrAddr, 2'b00} & MASK[32*i +: 32]) == (BASE[32*i +: 32] & MASK[32*i +: 32]);
         if (hit[i]) idx = IW'(i);
      end
      any_hit = |hit;
   end
endmodule

// File: rtl/sys_bridge_n.sv
// sys_bridge_n: CPU-to-peripheral bridge; decodes, forwards to one device, waits for ack
// with timeout, returns registered data/error, and registers device IRQs for CP0.
module sys_bridge_n
   import sys_bridge_n_pkg::*;
#(
   parameter int N_DEV = 6,
   parameter logic [32*N_DEV-1:0] BASE = DEF_BASE[32*N_DEV-1:0],
   parameter logic [32*N_DEV-1:0] MASK = DEF_MASK[32*N_DEV-1:0],
   parameter int TIMEOUT = 15
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [29:0]          PrAddr,
   input  logic [31:0]          PrWD,
   input  logic [3:0]           PrBE,
   input  logic                 PrWe,
   input  logic                 PrReq,
   output logic [31:0]          PrRD,
   output logic                 PrReady,
   output logic                 PrErr,
   output logic [29:0]          DEV_Addr,
   output logic [31:0]          DEV_WD,
   output logic [3:0]           DEV_BE,
   output logic [N_DEV-1:0]     DEV_Sel,
   output logic [N_DEV-1:0]     DEV_WE,
   input  logic [32*N_DEV-1:0]  DEV_RD,
   input  logic [N_DEV-1:0]     DEV_Ack,
   input  logic [N_DEV-1:0]     DEV_IRQ,
   output logic [HWINT_W-1:0]   HWInt
);
   localparam int IW = N_DEV > 1 ? $clog2(N_DEV) : 1;
   state_t state, state_n;
   logic [N_DEV-1:0] hit, sel;
   logic [IW-1:0] dec_idx, idx;
   logic any_hit, we, ack, timeout;
   logic [7:0] cnt;
   logic [31:0] rd;
   bridge_addr_dec #(.N_DEV(N_DEV), .IW(IW), .BASE(BASE), .MASK(MASK)) u_dec (
      .PrAddr(PrAddr), .hit(hit), .idx(dec_idx), .any_hit(any_hit)
   );
   assign ack = |(DEV_Ack & sel);
   assign rd = DEV_RD[{idx, 5'd0} +: 32];
   assign timeout = cnt == 8'(TIMEOUT - 1);
   always_comb begin
      state_n = state == IDLE   ? (PrReq ? (any_hit ? ACCESS : RESP) : IDLE) :
                state == ACCESS ? ((ack || timeout) ? RESP : ACCESS) : IDLE;
      DEV_Sel = state == ACCESS ? sel : '0;
      DEV_WE = we ? DEV_Sel : '0;
      PrReady = state == RESP;
   end
   // select lines come straight from state, so an async reset drops them at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         sel <= '0;
         we <= 1'b0;
         PrRD <= '0;
         PrErr <= 1'b0;
         DEV_Addr <= '0;
         DEV_WD <= '0;
         DEV_BE <= '0;
         HWInt <= '0;
      end else begin
         state <= state_n;
         HWInt <= HWINT_W'(DEV_IRQ);
         if (state == IDLE && PrReq) begin
            if (any_hit) begin
               DEV_Addr <= PrAddr;
               DEV_WD <= PrWD;
               DEV_BE <= PrBE;
               we <= PrWe;
               idx <= dec_idx;
               sel <= hit & (~hit + N_DEV'(1));
               cnt <= '0;
            end else begin
               PrRD <= '0;
               PrErr <= 1'b1;
            end
         end
         if (state == ACCESS) begin
            if (ack) begin
               PrRD <= we ? 32'd0 : rd;
               PrErr <= 1'b0;
            end else if (timeout) begin
               PrRD <= '0;
               PrErr <= 1'b1;
            end else cnt <= cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_sys_bridge_n.sv
// tb_sys_bridge_n: randomized self-checking bench against a behavioural address-map/latency model
module tb_sys_bridge_n;
   localparam int N = 6;
   localparam int TO = 15;
   logic clk = 1'b0, reset;
   logic [29:0] PrAddr, DEV_Addr;
   logic [31:0] PrWD, PrRD, DEV_WD;
   logic [3:0] PrBE, DEV_BE;
   logic PrWe, PrReq, PrReady, PrErr;
   logic [N-1:0] DEV_Sel, DEV_WE, DEV_Ack, DEV_IRQ;
   logic [32*N-1:0] DEV_RD;
   logic [5:0] HWInt;
   int cyc = 0, checks = 0, passed = 0, t_raise = 0, t_ready = 0;

   sys_bridge_n dut (
      .clk(clk), .reset(reset), .PrAddr(PrAddr), .PrWD(PrWD), .PrBE(PrBE), .PrWe(PrWe),
      .PrReq(PrReq), .PrRD(PrRD), .PrReady(PrReady), .PrErr(PrErr), .DEV_Addr(DEV_Addr),
      .DEV_WD(DEV_WD), .DEV_BE(DEV_BE), .DEV_Sel(DEV_Sel), .DEV_WE(DEV_WE), .DEV_RD(DEV_RD),
      .DEV_Ack(DEV_Ack), .DEV_IRQ(DEV_IRQ), .HWInt(HWInt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // default map: device i owns the 16-byte window starting at 0x7F00 + 16*i
   function automatic int ref_dev(input logic [29:0] wa);
      logic [31:0] a;
      a = {wa, 2'b00};
      for (int i = 0; i < N; i++) if (a / 16 == (32'h7F00 + 16 * i) / 16) return i;
      return -1;
   endfunction

   // ack_delay: -1 never acks, d acks in the (d+1)th ACCESS cycle
   task automatic do_txn(input logic [31:0] ba, input logic [31:0] wd, input logic [3:0] be,
                         input logic we, input int ack_delay, input logic [31:0] data, input string nm);
      int dev, exp_lat, exp_sel, sel_cyc, lat;
      logic [29:0] wa;
      logic [31:0] exp_rd;
      logic [N-1:0] oh;
      logic exp_err;
      bit done;
      wa = ba[31:2];
      dev = ref_dev(wa);
      oh = dev >= 0 ? N'(1) << dev : '0;
      if (dev < 0) begin exp_lat = 1; exp_sel = 0; exp_err = 1; exp_rd = 0; end
      else if (ack_delay < 0 || ack_delay >= TO) begin exp_lat = TO + 1; exp_sel = TO; exp_err = 1; exp_rd = 0; end
      else begin exp_lat = ack_delay + 2; exp_sel = ack_delay + 1; exp_err = 0; exp_rd = we ? 32'd0 : data; end
      @(negedge clk);
      PrAddr = wa; PrWD = wd; PrBE = be; PrWe = we; PrReq = 1'b1;
      t_raise = cyc;
      for (int i = 0; i < N; i++) DEV_RD[32*i +: 32] = (i == dev) ? data : $urandom;
      DEV_Ack = '0;
      sel_cyc = 0; lat = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         lat++;
         checks++;
         if (HWInt !== DEV_IRQ) $display("FAIL %s hwint: got %b want %b", nm, HWInt, DEV_IRQ);
         else passed++;
         DEV_IRQ = N'($urandom);
         if (PrReady) begin
            done = 1;
            checks++;
            if (DEV_Sel !== '0) $display("FAIL %s sel_in_resp: got %b want 0", nm, DEV_Sel);
            else passed++;
         end else begin
            if (DEV_Sel !== '0) sel_cyc++;
            checks++;
            if (DEV_Sel !== oh || DEV_WE !== (we ? oh : '0) || DEV_Addr !== wa || DEV_WD !== wd || DEV_BE !== be)
               $display("FAIL %s access: sel %b we %b addr %h wd %h be %b want sel %b we %b addr %h wd %h be %b",
                        nm, DEV_Sel, DEV_WE, DEV_Addr, DEV_WD, DEV_BE, oh, we ? oh : '0, wa, wd, be);
            else passed++;
            // busy-time changes on the CPU side must be ignored
            PrAddr = 30'($urandom); PrWD = $urandom; PrBE = 4'($urandom); PrWe = 1'($urandom);
            DEV_Ack = N'($urandom) & ~oh;
            if (dev >= 0 && sel_cyc == ack_delay + 1) DEV_Ack = DEV_Ack | oh;
         end
      end
      t_ready = cyc;
      PrReq = 1'b0;
      DEV_Ack = '0;
      checks++;
      if (!done) $display("FAIL %s ready: got none within 40 cycles want latency %0d", nm, exp_lat);
      else passed++;
      checks++;
      if (lat != exp_lat) $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat);
      else passed++;
      checks++;
      if (sel_cyc != exp_sel) $display("FAIL %s sel_cycles: got %0d want %0d", nm, sel_cyc, exp_sel);
      else passed++;
      checks++;
      if (PrRD !== exp_rd || PrErr !== exp_err)
         $display("FAIL %s resp: got rd %h err %b want rd %h err %b", nm, PrRD, PrErr, exp_rd, exp_err);
      else passed++;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (PrReady !== 1'b0 || PrRD !== '0 || PrErr !== 1'b0 || DEV_Sel !== '0 || DEV_WE !== '0 ||
          DEV_Addr !== '0 || DEV_WD !== '0 || DEV_BE !== '0 || HWInt !== '0)
         $display("FAIL reset: got rdy %b rd %h err %b sel %b we %b addr %h wd %h be %b hw %b want all 0",
                  PrReady, PrRD, PrErr, DEV_Sel, DEV_WE, DEV_Addr, DEV_WD, DEV_BE, HWInt);
      else passed++;
      reset = 1'b0;
   endtask

   task automatic test_read_dev1();
      do_txn(32'h7F14, 32'h0, 4'hF, 1'b0, 0, 32'hDEADBEEF, "read_dev1");
      @(negedge clk);
      checks++;
      if (PrReady !== 1'b0 || PrRD !== 32'hDEADBEEF || PrErr !== 1'b0)
         $display("FAIL read_dev1_hold: got rdy %b rd %h err %b want 0 deadbeef 0", PrReady, PrRD, PrErr);
      else passed++;
   endtask

   task automatic test_write_dev4();
      do_txn(32'h7F40, 32'h12345678, 4'b0011, 1'b1, 3, $urandom, "write_dev4");
   endtask

   task automatic test_unmapped();
      do_txn(32'h00001000, $urandom, 4'hF, 1'b0, 0, $urandom, "unmapped");
      @(negedge clk);
      checks++;
      if (PrReady !== 1'b0 || PrRD !== '0 || PrErr !== 1'b1)
         $display("FAIL unmapped_hold: got rdy %b rd %h err %b want 0 0 1", PrReady, PrRD, PrErr);
      else passed++;
   endtask

   task automatic test_timeout();
      do_txn(32'h7F00, $urandom, 4'hF, 1'b0, -1, $urandom, "timeout");
      do_txn(32'h7F04, $urandom, 4'hF, 1'b0, TO - 1, 32'hCAFEF00D, "timeout_edge_ack");
   endtask

   task automatic test_back_to_back();
      int t0;
      do_txn(32'h7F24, $urandom, 4'hF, 1'b0, 0, $urandom, "b2b0");
      t0 = t_raise;
      do_txn(32'h7F58, $urandom, 4'hF, 1'b1, 0, $urandom, "b2b1");
      do_txn(32'h7F08, $urandom, 4'hF, 1'b0, 0, $urandom, "b2b2");
      do_txn(32'h7F3C, $urandom, 4'hF, 1'b0, 0, $urandom, "b2b3");
      checks++;
      if (t_ready - t0 != 11) $display("FAIL back_to_back span: got %0d want 11", t_ready - t0);
      else passed++;
   endtask

   task automatic test_irq();
      @(negedge clk);
      DEV_IRQ = 6'b100001;
      @(negedge clk);
      checks++;
      if (HWInt !== 6'b100001) $display("FAIL irq: got %b want 100001", HWInt);
      else passed++;
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk);
      PrAddr = 30'h1FC8; PrWD = 32'hA5A5A5A5; PrBE = 4'hF; PrWe = 1'b1; PrReq = 1'b1; DEV_Ack = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (DEV_Sel !== 6'b000100 || DEV_WE !== 6'b000100)
         $display("FAIL rst_mid pre: got sel %b we %b want 000100 000100", DEV_Sel, DEV_WE);
      else passed++;
      #2 reset = 1'b1;
      #1;
      checks++;
      if (DEV_Sel !== '0 || DEV_WE !== '0) $display("FAIL rst_mid drop: got sel %b we %b want 0 0", DEV_Sel, DEV_WE);
      else passed++;
      PrReq = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (PrReady !== 1'b0) $display("FAIL rst_mid ready: got %b want 0", PrReady);
         else passed++;
      end
      reset = 1'b0;
      do_txn(32'h7F28, $urandom, 4'hF, 1'b0, 1, 32'h0BADC0DE, "after_reset");
   endtask

   task automatic test_random();
      logic [31:0] a;
      int d;
      for (int k = 0; k < 30; k++) begin
         a = $urandom_range(0, 3) == 0 ? (32'h10000 + $urandom_range(0, 32'hFFFF)) : (32'h7F00 + $urandom_range(0, 32'h6F));
         d = $urandom_range(0, 9) == 0 ? -1 : $urandom_range(0, 5);
         do_txn(a & 32'hFFFFFFFC, $urandom, 4'($urandom), 1'($urandom), d, $urandom, "random");
      end
   endtask

   initial begin
      reset = 1'b1;
      PrAddr = '0; PrWD = '0; PrBE = '0; PrWe = 1'b0; PrReq = 1'b0;
      DEV_RD = '0; DEV_Ack = '0; DEV_IRQ = 6'b101010;
      test_reset();
      test_read_dev1();
      test_write_dev4();
      test_unmapped();
      test_timeout();
      test_back_to_back();
      test_irq();
      test_reset_mid_access();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
